mux_n_reg_arb: RTL

//  N-channel, W-bit registered multiplexer with valid/ready handshake on every port.

---
 rtl/mux_n_reg_arb_pkg.sv | 16 +
 rtl/mux_n_reg_arb_rr_arbiter.sv | 34 +++
 rtl/mux_n_reg_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_n_reg_arb_pkg.sv
// Shared definitions for the N-channel registered mux/arbiter: mode encodings
// and the index-width helper used to size select and channel ports.
package mux_n_reg_arb_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Number of bits needed to index `value` items (at least 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/mux_n_reg_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter: scans requests starting at ptr and
// wrapping modulo N, reporting the first requester found.
module rr_arbiter
    import mux_n_reg_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // The first hit wins; later hits are ignored once gnt_any is set.
    always_comb begin
        int                sum;
        logic [SELW-1:0]   idx;
        sum     = 0;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = SELW'(sum);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg_arb.sv
// N-channel registered multiplexer with valid/ready on every port; selects by
// index (mode 0) or round-robin among valid channels (mode 1).
module mux_n_reg_arb
    import mux_n_reg_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] select,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    data_q,  data_d;
    logic [SELW-1:0] chan_q,  chan_d;
    logic            valid_q, valid_d;
    logic [SELW-1:0] ptr_q,   ptr_d;

    logic [SELW-1:0] rrIdx;
    logic            rrAny;
    logic [SELW-1:0] grantIdx;
    logic            grantAny;
    logic [W-1:0]    grantData;
    logic            load;
    logic            transferIn;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rrIdx),
        .gnt_any (rrAny)
    );

    // Select-mode grant only exists for an in-range index with its valid high.
    always_comb begin
        grantIdx = '0;
        grantAny = 1'b0;
        if (mode == MODE_RR) begin
            grantIdx = rrIdx;
            grantAny = rrAny;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (select == SELW'(i) && in_valid[i]) begin
                    grantIdx = select;
                    grantAny = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grantData = '0;
        for (int i = 0; i < N; i++) begin
            if (grantIdx == SELW'(i)) grantData = in_data[i*W +: W];
        end
    end

    // out_ready reaches in_ready combinationally through load.
    assign load       = !valid_q || out_ready;
    assign transferIn = !reset && load && grantAny;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = transferIn && (grantIdx == SELW'(i));
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (transferIn) begin
            data_d  = grantData;
            chan_d  = grantIdx;
            valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (int'(grantIdx) == N - 1) ? '0 : grantIdx + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule
